// File: rtl/i2s_sample_sched.sv
// Sample scheduler feeding i2s_master: two buffered producer streams, paced per frame tick, selected/mixed/muted.
// Build option: define I2S_SAMPLE_SCHED_SAT_EN to make the mix mode saturate instead of averaging.

module i2s_sample_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_pop,
    output logic [W-1:0] o_head,
    output logic         o_empty,
    output logic         o_ready
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_ready;
    logic [AW:0]   w_count_nxt;
    logic          w_wr;
    logic          w_rd;

    assign w_wr    = i_push && r_ready;
    assign w_rd    = i_pop && (r_count != {(AW+1){1'b0}});
    assign o_head  = r_mem[r_rd_ptr];
    assign o_empty = (r_count == {(AW+1){1'b0}});
    assign o_ready = r_ready;

    // Occupancy after this cycle's push/pop; simultaneous push and pop leave it unchanged.
    always_comb begin
        w_count_nxt = r_count;
        case ({w_wr, w_rd})
            2'b10:   w_count_nxt = r_count + {{AW{1'b0}}, 1'b1};
            2'b01:   w_count_nxt = r_count - {{AW{1'b0}}, 1'b1};
            default: w_count_nxt = r_count;
        endcase
    end

    // Pointers, count and registered ready flag.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= {(AW+1){1'b0}};
            r_ready  <= 1'b1;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + {{(AW-1){1'b0}}, 1'b1};
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + {{(AW-1){1'b0}}, 1'b1};
            end
            r_count <= w_count_nxt;
            r_ready <= (w_count_nxt != FULL_CNT);
        end
    end

    // Storage array; contents are don't-care once the pointers are reset.
    always_ff @(posedge i_clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

endmodule

module i2s_sample_sched #(
    parameter int DIV   = 24,
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_en,
    input  logic [1:0]   i_mode,
    input  logic         i_a_valid,
    output logic         o_a_ready,
    input  logic [W-1:0] i_a_data,
    input  logic         i_b_valid,
    output logic         o_b_ready,
    input  logic [W-1:0] i_b_data,
    output logic [W-1:0] o_smp,
    output logic         o_smp_stb,
    output logic [1:0]   o_und,
    input  logic         i_und_clr
);

    localparam logic [1:0] MODE_A    = 2'b00;
    localparam logic [1:0] MODE_B    = 2'b01;
    localparam logic [1:0] MODE_MIX  = 2'b10;
    localparam logic [1:0] MODE_MUTE = 2'b11;
    localparam logic [7:0] DIV_LAST  = 8'(DIV - 1);

    logic [7:0]   r_cnt;
    logic [W-1:0] r_smp;
    logic         r_stb;
    logic [1:0]   r_und;

    logic         w_tick;
    logic         w_pop_a;
    logic         w_pop_b;
    logic [W-1:0] w_a_head;
    logic [W-1:0] w_b_head;
    logic         w_a_empty;
    logic         w_b_empty;
    logic [W-1:0] w_a_term;
    logic [W-1:0] w_b_term;
    logic [W:0]   w_sum;
    logic [W-1:0] w_mix;
    logic [W-1:0] w_smp_nxt;
    logic [1:0]   w_und_set;

    assign w_tick  = i_en && (r_cnt == DIV_LAST);
    assign w_pop_a = w_tick && (i_mode != MODE_B);
    assign w_pop_b = w_tick && (i_mode != MODE_A);

    i2s_sample_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo_a (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (i_a_valid),
        .i_data  (i_a_data),
        .i_pop   (w_pop_a),
        .o_head  (w_a_head),
        .o_empty (w_a_empty),
        .o_ready (o_a_ready)
    );

    i2s_sample_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo_b (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (i_b_valid),
        .i_data  (i_b_data),
        .i_pop   (w_pop_b),
        .o_head  (w_b_head),
        .o_empty (w_b_empty),
        .o_ready (o_b_ready)
    );

    // Frame-period counter; disabling clears it so the next period starts fresh.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= 8'd0;
        end else if (!i_en || (r_cnt == DIV_LAST)) begin
            r_cnt <= 8'd0;
        end else begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    assign w_a_term = w_a_empty ? {W{1'b0}} : w_a_head;
    assign w_b_term = w_b_empty ? {W{1'b0}} : w_b_head;
    assign w_sum    = {w_a_term[W-1], w_a_term} + {w_b_term[W-1], w_b_term};

    // Mix reduction: clamp on sign disagreement of the extended sum, or halve it.
    always_comb begin
        w_mix = w_sum[W-1:0];
`ifdef I2S_SAMPLE_SCHED_SAT_EN
        if (w_sum[W] != w_sum[W-1]) begin
            w_mix = w_sum[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end else begin
            w_mix = w_sum[W-1:0];
        end
`else
        w_mix = w_sum[W:1];
`endif
    end

    // Next sample and underrun events; a lone empty source holds the previous sample.
    always_comb begin
        w_smp_nxt = r_smp;
        w_und_set = 2'b00;
        if (w_tick) begin
            case (i_mode)
                MODE_A: begin
                    if (w_a_empty) begin
                        w_und_set[0] = 1'b1;
                    end else begin
                        w_smp_nxt = w_a_head;
                    end
                end
                MODE_B: begin
                    if (w_b_empty) begin
                        w_und_set[1] = 1'b1;
                    end else begin
                        w_smp_nxt = w_b_head;
                    end
                end
                MODE_MIX: begin
                    w_smp_nxt = w_mix;
                    w_und_set = {w_b_empty, w_a_empty};
                end
                MODE_MUTE: begin
                    w_smp_nxt = {W{1'b0}};
                end
                default: begin
                    w_smp_nxt = r_smp;
                end
            endcase
        end else begin
            w_smp_nxt = r_smp;
        end
    end

    // Registered sample, strobe and sticky underrun flags (a new set beats a clear).
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_smp <= {W{1'b0}};
            r_stb <= 1'b0;
            r_und <= 2'b00;
        end else begin
            r_smp <= w_smp_nxt;
            r_stb <= w_tick;
            r_und <= (i_und_clr ? 2'b00 : r_und) | w_und_set;
        end
    end

    assign o_smp     = r_smp;
    assign o_smp_stb = r_stb;
    assign o_und     = r_und;

endmodule

// File: tb/tb_i2s_sample_sched.sv
// Scoreboard bench for i2s_sample_sched: stimulus queues expected {und, smp} per tick, a monitor checks each strobe.

module tb_i2s_sample_sched;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic [1:0]   mode;
    logic         a_valid;
    logic         a_ready;
    logic [W-1:0] a_data;
    logic         b_valid;
    logic         b_ready;
    logic [W-1:0] b_data;
    logic [W-1:0] smp;
    logic         smp_stb;
    logic [1:0]   und;
    logic         und_clr;

    int n_vec = 0;
    int n_err = 0;
    logic [17:0] exp_q[$];
    logic [17:0] mon_e;

    always #5 clk = ~clk;

    i2s_sample_sched dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_en      (en),
        .i_mode    (mode),
        .i_a_valid (a_valid),
        .o_a_ready (a_ready),
        .i_a_data  (a_data),
        .i_b_valid (b_valid),
        .o_b_ready (b_ready),
        .i_b_data  (b_data),
        .o_smp     (smp),
        .o_smp_stb (smp_stb),
        .o_und     (und),
        .i_und_clr (und_clr)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, want);
        end
    endtask

    // Monitor: every strobe consumes one expected entry.
    always @(negedge clk) begin
        if (smp_stb === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_stb: got smp 0x%0h, want no strobe", smp);
            end else begin
                mon_e = exp_q.pop_front();
                check("smp", {16'h0, smp}, {16'h0, mon_e[15:0]});
                check("und", {30'h0, und}, {30'h0, mon_e[17:16]});
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_tick(input logic [15:0] s, input logic [1:0] u);
        exp_q.push_back({u, s});
    endtask

    task automatic push_a(input logic [15:0] d);
        a_valid = 1'b1; a_data = d;
        step(1);
        a_valid = 1'b0;
    endtask

    task automatic push_ab(input logic [15:0] da, input logic [15:0] db);
        a_valid = 1'b1; a_data = da;
        b_valid = 1'b1; b_data = db;
        step(1);
        a_valid = 1'b0; b_valid = 1'b0;
    endtask

    task automatic wait_stb();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 64; i++) begin
            step(1);
            if (smp_stb) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            n_vec++;
            n_err++;
            $display("FAIL stb_timeout: got no strobe in 64 cycles, want one");
        end
    endtask

    task automatic count_to_stb(output int c);
        c = 0;
        for (int i = 1; i <= 64; i++) begin
            step(1);
            if (smp_stb) begin
                c = i;
                break;
            end
        end
    endtask

    task automatic clr_und();
        und_clr = 1'b1;
        step(1);
        und_clr = 1'b0;
        check("und_clr", {30'h0, und}, 32'h0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish, want finish");
        $fatal(1);
    end

    initial begin
        int c;
        rst = 1'b1; en = 1'b0; mode = 2'b00;
        a_valid = 1'b0; a_data = 16'h0; b_valid = 1'b0; b_data = 16'h0; und_clr = 1'b0;
        step(2);
        check("rst_smp", {16'h0, smp}, 32'h0);
        check("rst_stb", {31'h0, smp_stb}, 32'h0);
        check("rst_und", {30'h0, und}, 32'h0);
        check("rst_a_ready", {31'h0, a_ready}, 32'h1);
        check("rst_b_ready", {31'h0, b_ready}, 32'h1);

        // First sample: push at cycle 3, strobe at cycle 24.
        rst = 1'b0; en = 1'b1;
        expect_tick(16'h1234, 2'b00);
        c = 0;
        for (int i = 1; i <= 40; i++) begin
            if (i == 3) begin
                a_valid = 1'b1; a_data = 16'h1234;
            end else begin
                a_valid = 1'b0;
            end
            step(1);
            if (smp_stb) begin
                c = i;
                break;
            end
        end
        a_valid = 1'b0;
        check("first_stb_cycle", c, 24);

        // Underrun holds the previous sample and sets und[0].
        expect_tick(16'h0100, 2'b00);
        push_a(16'h0100);
        wait_stb();
        for (int i = 0; i < 3; i++) expect_tick(16'h0100, 2'b01);
        for (int i = 0; i < 3; i++) wait_stb();
        clr_und();

        // Fill A beyond DEPTH; the fifth word is refused.
        for (int i = 0; i < 5; i++) begin
            a_valid = 1'b1; a_data = 16'h0011 + 16'(i);
            step(1);
            check("a_ready_fill", {31'h0, a_ready}, (i < 3) ? 32'h1 : 32'h0);
        end
        a_valid = 1'b0;
        expect_tick(16'h0011, 2'b00);
        expect_tick(16'h0012, 2'b00);
        expect_tick(16'h0013, 2'b00);
        expect_tick(16'h0014, 2'b00);
        expect_tick(16'h0014, 2'b01);
        wait_stb();
        check("a_ready_after_pop", {31'h0, a_ready}, 32'h1);
        for (int i = 0; i < 4; i++) wait_stb();
        clr_und();

        // Mode glitches between ticks are ignored.
        push_a(16'h5555);
        step(5); mode = 2'b11;
        step(5); mode = 2'b00;
        expect_tick(16'h5555, 2'b00);
        wait_stb();

        // Mix mode.
        mode = 2'b10;
`ifdef I2S_SAMPLE_SCHED_SAT_EN
        expect_tick(16'h7FFF, 2'b00);
        expect_tick(16'h8000, 2'b00);
        expect_tick(16'h0100, 2'b10);
`else
        expect_tick(16'h4800, 2'b00);
        expect_tick(16'hB800, 2'b00);
        expect_tick(16'h0080, 2'b10);
`endif
        push_ab(16'h7000, 16'h2000);
        wait_stb();
        push_ab(16'h8000, 16'hF000);
        wait_stb();
        push_a(16'h0100);
        wait_stb();
        clr_und();

        // Mute drains both FIFOs without underrun.
        mode = 2'b11;
        push_ab(16'h1111, 16'h3333);
        push_ab(16'h2222, 16'h4444);
        expect_tick(16'h0000, 2'b00);
        expect_tick(16'h0000, 2'b00);
        wait_stb();
        wait_stb();
        mode = 2'b00;
        expect_tick(16'h0000, 2'b01);
        wait_stb();
        mode = 2'b01;
        expect_tick(16'h0000, 2'b11);
        wait_stb();
        clr_und();

        // Push into empty A during the tick cycle: no bypass.
        mode = 2'b00;
        expect_tick(16'h0000, 2'b01);
        expect_tick(16'h7777, 2'b01);
        step(22);
        push_a(16'h7777);
        check("tick_align_stb", {31'h0, smp_stb}, 32'h1);
        wait_stb();

        // Async reset mid-period discards queued words.
        push_a(16'h6666);
        step(5);
        rst = 1'b1;
        #1;
        check("arst_smp", {16'h0, smp}, 32'h0);
        check("arst_und", {30'h0, und}, 32'h0);
        check("arst_a_ready", {31'h0, a_ready}, 32'h1);
        @(posedge clk); #1;
        expect_tick(16'h0000, 2'b01);
        rst = 1'b0;
        count_to_stb(c);
        check("post_rst_stb_cycle", c, 24);

        // Disable mid-period clears the counter.
        step(10);
        en = 1'b0;
        step(30);
        expect_tick(16'h0000, 2'b01);
        en = 1'b1;
        count_to_stb(c);
        check("reenable_stb_cycle", c, 24);

        step(5);
        check("queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/i2s_sample_sched.md
# i2s_sample_sched

Sample scheduler between the audio sample producers (sine table, SID voice path) and `i2s_master`. Buffers two producer streams in small FIFOs and paces consumption at the I2S frame rate. At each frame tick it selects, mixes or mutes the streams and presents one registered sample on the `i2s_master` `SMP` input. It replaces the free-running sample timer in `top` and reports per-source underruns.

## Interface
- `DIV`, 24, clock cycles per sample period; the frame tick fires once per `DIV` cycles; legal range 2..255.
- `W`, 16, sample width, two's-complement signed.
- `DEPTH`, 4, entries per source FIFO; power of two, 2..16.

- `clk`  in  1  system clock (`sys_clk` at top).
- `rst`  in  1  reset; asynchronous, active-high.
- `en`  in  1  scheduler enable; low holds the tick counter at 0 and suppresses ticks.
- `mode`  in  2  00 = source A, 01 = source B, 10 = mix A+B, 11 = mute.
- `a_valid` / `a_ready` / `a_data`  in / out / in W  source A push handshake.
- `b_valid` / `b_ready` / `b_data`  in / out / in W  source B push handshake.
- `smp`  out  W  current sample to `i2s_master.SMP`.
- `smp_stb`  out  1  one-cycle pulse, high in the cycle `smp` takes a new value.
- `und`  out  2  sticky underrun flags: bit0 = A, bit1 = B.
- `und_clr`  in  1  clears `und`.

## Operation
- Reset values: `smp`=0, `smp_stb`=0, `und`=0, both FIFOs empty, tick counter 0, `a_ready`=`b_ready`=1.
- Push: an entry is written when `x_valid && x_ready`. `x_ready` = FIFO not full, registered from the FIFO count. No write while full.
- Tick counter counts 0..DIV-1 while `en`=1 and wraps to 0. `tick` = (count == DIV-1) && `en`. When `en` goes low, the counter clears to 0 on the next edge.
- `mode` is sampled only on `tick`. Changes between ticks have no effect until the next tick.
- On `tick`, the FIFO of every source used by `mode` is popped if non-empty:
  - Mode 00 / 01: the single source is popped. If it is empty, `smp` holds its previous value and the source's `und` bit is set.
  - Mode 10: both sources are popped independently. An empty side contributes 0 and sets its `und` bit. The sum is formed W+1 bits wide, then reduced per Configuration.
  - Mode 11: both FIFOs are popped if non-empty, so the producers stay paced. `smp` becomes 0. No underrun is flagged.
- Sources not used by the current mode are not popped.
- `und` bits: a set and `und_clr` in the same cycle leaves the bit set (set wins).
- Push and pop in the same cycle on a non-empty FIFO: both occur and the count is unchanged.
- Push into an empty FIFO in the tick cycle: there is no bypass. The pop sees empty, the underrun is flagged, and the pushed word is kept for the next tick.
- Pointers wrap modulo DEPTH. Count is log2(DEPTH)+1 bits.

## Timing
- `smp` and `smp_stb` are registered and update on the edge after the `tick` cycle. `smp_stb` is high for exactly that one cycle.
- `smp_stb` pulses every tick, including ticks in mute and underrun.
- Latency from a push (accepted at edge k) to that word appearing on `smp`: next tick + 1 cycle. Minimum 2 cycles.
- `x_ready` deasserts on the edge at which the count reaches DEPTH. It reasserts on the edge after the pop.
- Asynchronous `rst` mid-operation clears everything immediately. All FIFO contents are discarded. The first tick after release comes DIV cycles after the first enabled edge.

## Configuration
- `I2S_SAMPLE_SCHED_SAT_EN`:
  - Defined: the mode-10 sum saturates to the signed W range, i.e. +32767 / −32768 for W=16.
  - Undefined: mode 10 outputs the arithmetic average, (A+B)>>>1, W+1 bit sum truncated after the shift.
  - Modes 00/01/11 are identical in both builds.

## Test plan
- Reset, `en`=1, mode 00, push A=0x1234 at cycle 3 -> `smp`=0x1234 with `smp_stb` one cycle after the first tick (cycle 24); `und`=00.
- Mode 00, no pushes for 3 ticks after a sample of 0x0100 -> `smp` stays 0x0100; `smp_stb` pulses 3 times; `und`=01; `und_clr` pulse -> `und`=00.
- Push 5 words to A with no tick -> `a_ready` low after the 4th accept; the 5th is not taken. After one tick, `a_ready`=1 and the FIFO count is 3.
- Mode 10, A=0x7000, B=0x2000 -> with `I2S_SAMPLE_SCHED_SAT_EN`: `smp`=0x7FFF; without: `smp`=0x4800. A=0x8000, B=0xF000 with SAT -> 0x8000.
- Mode 11 with 2 words in each FIFO -> two ticks give `smp`=0 and empty both FIFOs; `und`=00.
- `rst` asserted for 1 cycle mid-period with words queued -> `smp`=0, FIFOs empty, `und`=0 immediately; next `smp_stb` at DIV cycles after release + 1.
